// File: rtl/mag_cross_detect.sv
// Debounces per-sample e/l/g comparator verdicts into a BELOW/ABOVE state with
// HOLD-sample hysteresis, emitting rise/fall crossing pulses and saturating event counts.
module mag_cross_detect #(
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             e,
    input  logic             l,
    input  logic             g,
    output logic [1:0]       state,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_BELOW   = 2'd1,
        ST_ABOVE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAND_NONE  = 2'd0,
        CAND_BELOW = 2'd1,
        CAND_ABOVE = 2'd2
    } cand_t;

    localparam logic [3:0] HOLD_L = 4'(HOLD);

    state_t           st_q, st_d;
    cand_t            cand_q, cand_d;
    logic [3:0]       run_q, run_d;
    logic             rise_d, fall_d, err_d;
    logic             rise_q, fall_q, err_q;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic             legal;
    cand_t            dir_c;
    state_t           dir_s;

    assign legal = (e & ~l & ~g) | (~e & l & ~g) | (~e & ~l & g);
    assign dir_c = g ? CAND_ABOVE : CAND_BELOW;
    assign dir_s = g ? ST_ABOVE : ST_BELOW;

    always_comb begin
        st_d       = st_q;
        cand_d     = cand_q;
        run_d      = run_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        err_d      = 1'b0;
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        eq_cnt_d   = eq_cnt_q;

        if (in_valid) begin
            if (!legal) begin
                cand_d = CAND_NONE;
                run_d  = 4'd0;
                err_d  = 1'b1;
            end else if (e) begin
                if (eq_cnt_q != '1) eq_cnt_d = eq_cnt_q + CNT_W'(1);
            end else begin
                if (cand_q == dir_c) begin
                    run_d = (run_q == HOLD_L) ? run_q : run_q + 4'd1;
                end else begin
                    cand_d = dir_c;
                    run_d  = 4'd1;
                end
                // Confirmation looks at the post-update run, so HOLD=1 flips on the same sample.
                if (run_d == HOLD_L && dir_s != st_q) begin
                    st_d = dir_s;
                    if (st_q == ST_BELOW) begin
                        rise_d = 1'b1;
                        if (rise_cnt_q != '1) rise_cnt_d = rise_cnt_q + CNT_W'(1);
                    end else if (st_q == ST_ABOVE) begin
                        fall_d = 1'b1;
                        if (fall_cnt_q != '1) fall_cnt_d = fall_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= ST_UNKNOWN;
            cand_q     <= CAND_NONE;
            run_q      <= 4'd0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            err_q      <= 1'b0;
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
            eq_cnt_q   <= '0;
        end else begin
            st_q       <= st_d;
            cand_q     <= cand_d;
            run_q      <= run_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            err_q      <= err_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            eq_cnt_q   <= eq_cnt_d;
        end
    end

    assign state      = st_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign err        = err_q;
    assign rise_cnt   = rise_cnt_q;
    assign fall_cnt   = fall_cnt_q;
    assign eq_cnt     = eq_cnt_q;

endmodule

// File: doc/mag_cross_detect.md
Name: mag_cross_detect

Overview:
- Sits directly downstream of the 4-bit magnitude comparator.
- Consumes the comparator's per-sample e/l/g verdicts (x vs y) under a valid strobe.
- Debounces the verdicts into a stable BELOW/ABOVE state, using hysteresis of HOLD consecutive agreeing samples.
- Emits single-cycle rise/fall crossing pulses with saturating event counters, for threshold monitoring of a sampled 4-bit value.

Parameters:
- HOLD, 3, number of consecutive agreeing non-equal samples required to confirm a state change; legal range 1..15.
- CNT_W, 8, width of the rise/fall/equal event counters.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  e/l/g carry a new comparator verdict this cycle.
- e  input  1  comparator x==y.
- l  input  1  comparator x<y.
- g  input  1  comparator x>y.
- state  output  2  debounced state: 2'd0 UNKNOWN, 2'd1 BELOW, 2'd2 ABOVE; 2'd3 is never driven.
- rise_pulse  output  1  one-cycle pulse on a confirmed BELOW->ABOVE transition.
- fall_pulse  output  1  one-cycle pulse on a confirmed ABOVE->BELOW transition.
- rise_cnt  output  CNT_W  saturating count of rise_pulse events.
- fall_cnt  output  CNT_W  saturating count of fall_pulse events.
- eq_cnt  output  CNT_W  saturating count of accepted equal samples.
- err  output  1  one-cycle pulse: accepted sample had an illegal e/l/g code.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=UNKNOWN; rise_pulse=fall_pulse=err=0; all counters=0.
  - Internal candidate direction=NONE; run length=0.
  - Reset overrides a simultaneous in_valid.
  - Reset mid-run discards the partial run entirely.
- Sample acceptance: a sample is processed only on a cycle with in_valid=1. With in_valid=0, all internal state holds and all pulses are 0.
- Legal codes: exactly one of e, l, g high. Any other code (000, 011, 101, 110, 111):
  - err=1 on the next cycle.
  - Candidate reset to NONE, run length=0.
  - state and counters unchanged.
- g sample:
  - If candidate==ABOVE, run length increments, saturating at HOLD.
  - Otherwise candidate=ABOVE and run length=1.
- l sample: symmetric to g, with BELOW.
- e sample:
  - Neutral: candidate and run length hold; an equal neither breaks nor extends a run.
  - eq_cnt increments, saturating at all-ones.
- Confirmation: evaluated on the updated run length. If run length==HOLD and candidate differs from state:
  - state<=candidate.
  - BELOW->ABOVE: rise_pulse=1 and rise_cnt increments.
  - ABOVE->BELOW: fall_pulse=1 and fall_cnt increments.
  - UNKNOWN->either: state updates with no pulse and no count.
- Latency: state, pulses, err and counters are all registered. They reflect the confirming or offending sample one clk after the accepting edge, i.e. visible in the cycle following the in_valid cycle.
- Pulses last exactly one cycle even if in_valid stays high. A run saturated at HOLD that continues agreeing with state produces no further pulses.
- HOLD=1: every legal non-equal sample that disagrees with state flips it immediately.
- Counter saturation: a counter at all-ones stays at all-ones. The pulse still fires at saturation.
- rise_pulse and fall_pulse are never high together. err is never high with either pulse.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, g=1 -> state=0, all counters=0, no pulses; release; first g sample starts a run of length 1.
- Initial lock, HOLD=3: g,g,g on consecutive valid cycles -> state=2 after the third, rise_pulse=0, rise_cnt=0. Then l,l,l -> state=1, fall_pulse=1 for one cycle, fall_cnt=1.
- Hysteresis with equals, starting from BELOW: g,g,e,l,g,g,e,g -> equals neutral, l breaks the run. State goes ABOVE only on the final g (third consecutive g excluding equals), rise_cnt=1, eq_cnt=2.
- Gaps: from BELOW, g, in_valid=0 for 5 cycles, g, g -> state=2 with rise_pulse on the cycle after the last g; nothing changes during the gap.
- Illegal code: from ABOVE, l,l, then e=l=1, then l,l -> err pulse after the illegal sample; state remains 2 until the third l overall after err is not reached (only 2). A third l then sets state=1 and fall_pulse=1.
- Saturation (CNT_W=2): drive 5 full BELOW->ABOVE->BELOW cycles -> rise_cnt and fall_cnt stop at 3, pulses still fire each time.
